// File: rtl/mult_rs.sv
// mult_rs: reservation station in front of a single non-pipelined multiplier.
// Holds dispatched ops, wakes sources from the CDB and issues one ready op at a time.
module mult_rs #(
  parameter int PHYS_REG_BITS = 6,
  parameter int ROB_IDX_BITS  = 4,
  parameter int DEPTH         = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     dispatch_valid,
  output logic                     dispatch_ready,
  input  logic [2:0]               dispatch_funct3,
  input  logic [PHYS_REG_BITS-1:0] dispatch_ps1,
  input  logic [PHYS_REG_BITS-1:0] dispatch_ps2,
  input  logic                     dispatch_ps1_rdy,
  input  logic                     dispatch_ps2_rdy,
  input  logic [PHYS_REG_BITS-1:0] dispatch_pd,
  input  logic [ROB_IDX_BITS-1:0]  dispatch_rob_idx,
  input  logic                     cdb_valid,
  input  logic [PHYS_REG_BITS-1:0] cdb_pd,
  input  logic                     fu_valid,
  input  logic                     flush,
  output logic                     issue_valid,
  output logic [2:0]               issue_funct3,
  output logic [PHYS_REG_BITS-1:0] issue_ps1,
  output logic [PHYS_REG_BITS-1:0] issue_ps2,
  output logic [PHYS_REG_BITS-1:0] issue_pd,
  output logic [ROB_IDX_BITS-1:0]  issue_rob_idx
);
  localparam int IDX_BITS = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [DEPTH-1:0] ONE_HOT0 = {{(DEPTH-1){1'b0}}, 1'b1};

  typedef logic [PHYS_REG_BITS-1:0] tag_t;
  typedef logic [ROB_IDX_BITS-1:0]  rob_t;
  typedef logic [IDX_BITS-1:0]      idx_t;

  logic [DEPTH-1:0] valid_q, valid_d, rdy1_q, rdy1_d, rdy2_q, rdy2_d;
  logic [2:0]       funct3_q [DEPTH];
  logic [2:0]       funct3_d [DEPTH];
  tag_t             ps1_q [DEPTH];
  tag_t             ps1_d [DEPTH];
  tag_t             ps2_q [DEPTH];
  tag_t             ps2_d [DEPTH];
  tag_t             pd_q  [DEPTH];
  tag_t             pd_d  [DEPTH];
  rob_t             rob_q [DEPTH];
  rob_t             rob_d [DEPTH];

  logic       busy_q, busy_d;
  logic       iss_valid_q, iss_valid_d;
  logic [2:0] iss_funct3_q, iss_funct3_d;
  tag_t       iss_ps1_q, iss_ps1_d, iss_ps2_q, iss_ps2_d, iss_pd_q, iss_pd_d;
  rob_t       iss_rob_q, iss_rob_d;

  logic [DEPTH-1:0] cand_s, disp_mask_s, iss_mask_s;
  idx_t             free_idx_s, sel_idx_s;
  logic             sel_found_s, do_dispatch_s, do_issue_s, disp_r1_s, disp_r2_s;

  assign cand_s         = valid_q & rdy1_q & rdy2_q;
  assign dispatch_ready = ~&valid_q;
  assign do_dispatch_s  = dispatch_valid & dispatch_ready & ~flush;
  assign do_issue_s     = sel_found_s & ~busy_q & ~flush;
  assign disp_mask_s    = do_dispatch_s ? (ONE_HOT0 << free_idx_s) : {DEPTH{1'b0}};
  assign iss_mask_s     = do_issue_s ? (ONE_HOT0 << sel_idx_s) : {DEPTH{1'b0}};

  // Tag 0 is the hard-wired zero register, so it never needs a wakeup.
  assign disp_r1_s = dispatch_ps1_rdy | (dispatch_ps1 == '0) | (cdb_valid & (cdb_pd == dispatch_ps1));
  assign disp_r2_s = dispatch_ps2_rdy | (dispatch_ps2 == '0) | (cdb_valid & (cdb_pd == dispatch_ps2));

  // Lowest-index free slot and lowest-index fully ready slot (scan downward so lowest wins).
  always_comb begin
    free_idx_s  = '0;
    sel_idx_s   = '0;
    sel_found_s = 1'b0;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      free_idx_s  = valid_q[i] ? free_idx_s : idx_t'(i);
      sel_idx_s   = cand_s[i] ? idx_t'(i) : sel_idx_s;
      sel_found_s = sel_found_s | cand_s[i];
    end
  end

  // Per-entry next state: dispatch write, CDB wakeup, issue release, flush clear.
  always_comb begin
    valid_d  = valid_q;
    rdy1_d   = rdy1_q;
    rdy2_d   = rdy2_q;
    funct3_d = funct3_q;
    ps1_d    = ps1_q;
    ps2_d    = ps2_q;
    pd_d     = pd_q;
    rob_d    = rob_q;
    for (int i = 0; i < DEPTH; i++) begin
      if (flush) begin
        valid_d[i] = 1'b0;
      end else if (disp_mask_s[i]) begin
        valid_d[i] = 1'b1;
      end else if (iss_mask_s[i]) begin
        valid_d[i] = 1'b0;
      end else begin
        valid_d[i] = valid_q[i];
      end
      if (disp_mask_s[i]) begin
        funct3_d[i] = dispatch_funct3;
        ps1_d[i]    = dispatch_ps1;
        ps2_d[i]    = dispatch_ps2;
        pd_d[i]     = dispatch_pd;
        rob_d[i]    = dispatch_rob_idx;
        rdy1_d[i]   = disp_r1_s;
        rdy2_d[i]   = disp_r2_s;
      end else begin
        rdy1_d[i] = rdy1_q[i] | (valid_q[i] & cdb_valid & (ps1_q[i] == cdb_pd));
        rdy2_d[i] = rdy2_q[i] | (valid_q[i] & cdb_valid & (ps2_q[i] == cdb_pd));
      end
    end
  end

  // Issue register and multiplier-busy tracking; a stray fu_valid while idle is harmless.
  always_comb begin
    iss_funct3_d = iss_funct3_q;
    iss_ps1_d    = iss_ps1_q;
    iss_ps2_d    = iss_ps2_q;
    iss_pd_d     = iss_pd_q;
    iss_rob_d    = iss_rob_q;
    if (do_issue_s) begin
      iss_valid_d  = 1'b1;
      iss_funct3_d = funct3_q[sel_idx_s];
      iss_ps1_d    = ps1_q[sel_idx_s];
      iss_ps2_d    = ps2_q[sel_idx_s];
      iss_pd_d     = pd_q[sel_idx_s];
      iss_rob_d    = rob_q[sel_idx_s];
    end else begin
      iss_valid_d = 1'b0;
    end
    if (flush) begin
      busy_d = 1'b0;
    end else if (do_issue_s) begin
      busy_d = 1'b1;
    end else if (fu_valid) begin
      busy_d = 1'b0;
    end else begin
      busy_d = busy_q;
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q      <= '0;
      rdy1_q       <= '0;
      rdy2_q       <= '0;
      funct3_q     <= '{default: '0};
      ps1_q        <= '{default: '0};
      ps2_q        <= '{default: '0};
      pd_q         <= '{default: '0};
      rob_q        <= '{default: '0};
      busy_q       <= 1'b0;
      iss_valid_q  <= 1'b0;
      iss_funct3_q <= 3'b000;
      iss_ps1_q    <= '0;
      iss_ps2_q    <= '0;
      iss_pd_q     <= '0;
      iss_rob_q    <= '0;
    end else begin
      valid_q      <= valid_d;
      rdy1_q       <= rdy1_d;
      rdy2_q       <= rdy2_d;
      funct3_q     <= funct3_d;
      ps1_q        <= ps1_d;
      ps2_q        <= ps2_d;
      pd_q         <= pd_d;
      rob_q        <= rob_d;
      busy_q       <= busy_d;
      iss_valid_q  <= iss_valid_d;
      iss_funct3_q <= iss_funct3_d;
      iss_ps1_q    <= iss_ps1_d;
      iss_ps2_q    <= iss_ps2_d;
      iss_pd_q     <= iss_pd_d;
      iss_rob_q    <= iss_rob_d;
    end
  end

  assign issue_valid   = iss_valid_q;
  assign issue_funct3  = iss_funct3_q;
  assign issue_ps1     = iss_ps1_q;
  assign issue_ps2     = iss_ps2_q;
  assign issue_pd      = iss_pd_q;
  assign issue_rob_idx = iss_rob_q;

endmodule

// File: tb/tb_mult_rs.sv
// Bench for mult_rs: directed cycle table plus randomized traffic against a slot-list model.
module tb_mult_rs;
  localparam int PRB = 6;
  localparam int RIB = 4;
  localparam int D   = 4;

  logic           clk = 1'b0;
  logic           rst_n, dispatch_valid, dispatch_ready;
  logic [2:0]     dispatch_funct3;
  logic [PRB-1:0] dispatch_ps1, dispatch_ps2, dispatch_pd, cdb_pd;
  logic           dispatch_ps1_rdy, dispatch_ps2_rdy, cdb_valid, fu_valid, flush;
  logic [RIB-1:0] dispatch_rob_idx;
  logic           issue_valid;
  logic [2:0]     issue_funct3;
  logic [PRB-1:0] issue_ps1, issue_ps2, issue_pd;
  logic [RIB-1:0] issue_rob_idx;

  int n_checks = 0;
  int n_err    = 0;

  always #5 clk = ~clk;

  mult_rs #(.PHYS_REG_BITS(PRB), .ROB_IDX_BITS(RIB), .DEPTH(D)) dut (
    .clk(clk), .rst_n(rst_n),
    .dispatch_valid(dispatch_valid), .dispatch_ready(dispatch_ready),
    .dispatch_funct3(dispatch_funct3), .dispatch_ps1(dispatch_ps1), .dispatch_ps2(dispatch_ps2),
    .dispatch_ps1_rdy(dispatch_ps1_rdy), .dispatch_ps2_rdy(dispatch_ps2_rdy),
    .dispatch_pd(dispatch_pd), .dispatch_rob_idx(dispatch_rob_idx),
    .cdb_valid(cdb_valid), .cdb_pd(cdb_pd), .fu_valid(fu_valid), .flush(flush),
    .issue_valid(issue_valid), .issue_funct3(issue_funct3), .issue_ps1(issue_ps1),
    .issue_ps2(issue_ps2), .issue_pd(issue_pd), .issue_rob_idx(issue_rob_idx)
  );

  // Reference model: a list of slots plus a busy flag and the last issued op.
  typedef struct {
    bit             v;
    logic [2:0]     f3;
    logic [PRB-1:0] ps1, ps2, pd;
    bit             r1, r2;
    logic [RIB-1:0] rob;
  } ent_t;

  ent_t           m [D];
  bit             m_busy, m_iv;
  logic [2:0]     m_f3;
  logic [PRB-1:0] m_ps1, m_ps2, m_pd;
  logic [RIB-1:0] m_rob;

  function automatic bit m_ready();
    bit r = 1'b0;
    for (int i = 0; i < D; i++) if (!m[i].v) r = 1'b1;
    return r;
  endfunction

  function automatic void model_step();
    int   sel = -1;
    int   fr  = -1;
    ent_t nx [D];
    if (!rst_n) begin
      for (int i = 0; i < D; i++) m[i] = '{1'b0, 3'd0, 6'd0, 6'd0, 6'd0, 1'b0, 1'b0, 4'd0};
      m_busy = 0; m_iv = 0; m_f3 = 0; m_ps1 = 0; m_ps2 = 0; m_pd = 0; m_rob = 0;
      return;
    end
    for (int i = D - 1; i >= 0; i--) begin
      if (m[i].v && m[i].r1 && m[i].r2) sel = i;
      if (!m[i].v) fr = i;
    end
    if (m_busy || flush) sel = -1;
    nx = m;
    for (int i = 0; i < D; i++) begin
      if (m[i].v && cdb_valid && m[i].ps1 == cdb_pd) nx[i].r1 = 1;
      if (m[i].v && cdb_valid && m[i].ps2 == cdb_pd) nx[i].r2 = 1;
    end
    if (fu_valid) m_busy = 0;
    m_iv = 0;
    if (sel >= 0) begin
      nx[sel].v = 0; m_busy = 1; m_iv = 1;
      m_f3 = m[sel].f3; m_ps1 = m[sel].ps1; m_ps2 = m[sel].ps2; m_pd = m[sel].pd; m_rob = m[sel].rob;
    end
    if (dispatch_valid && fr >= 0 && !flush) begin
      nx[fr].v   = 1;
      nx[fr].f3  = dispatch_funct3;
      nx[fr].ps1 = dispatch_ps1;
      nx[fr].ps2 = dispatch_ps2;
      nx[fr].pd  = dispatch_pd;
      nx[fr].rob = dispatch_rob_idx;
      nx[fr].r1  = dispatch_ps1_rdy || dispatch_ps1 == 0 || (cdb_valid && cdb_pd == dispatch_ps1);
      nx[fr].r2  = dispatch_ps2_rdy || dispatch_ps2 == 0 || (cdb_valid && cdb_pd == dispatch_ps2);
    end
    if (flush) begin
      for (int i = 0; i < D; i++) nx[i].v = 0;
      m_busy = 0; m_iv = 0;
    end
    m = nx;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: actual=%0d required=%0d", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    @(negedge clk);
    chk("model_dispatch_ready", {31'd0, dispatch_ready}, {31'd0, m_ready()});
    chk("model_issue_valid", {31'd0, issue_valid}, {31'd0, m_iv});
    chk("model_issue_funct3", {29'd0, issue_funct3}, {29'd0, m_f3});
    chk("model_issue_ps1", {26'd0, issue_ps1}, {26'd0, m_ps1});
    chk("model_issue_ps2", {26'd0, issue_ps2}, {26'd0, m_ps2});
    chk("model_issue_pd", {26'd0, issue_pd}, {26'd0, m_pd});
    chk("model_issue_rob", {28'd0, issue_rob_idx}, {28'd0, m_rob});
  endtask

  // One table row: inputs for a cycle and the outputs expected after its clock edge.
  typedef struct {
    bit rst, dv;
    int ps1; bit r1; int ps2; bit r2; int pd, rob;
    bit cv; int cpd; bit fu, fl;
    bit er, eiv; int epd;
  } vec_t;

  vec_t vq [$];

  function automatic vec_t v(bit rst, bit dv, int ps1, bit r1, int ps2, bit r2, int pd, int rob,
                             bit cv, int cpd, bit fu, bit fl, bit er, bit eiv, int epd);
    vec_t x;
    x.rst = rst; x.dv = dv; x.ps1 = ps1; x.r1 = r1; x.ps2 = ps2; x.r2 = r2; x.pd = pd; x.rob = rob;
    x.cv = cv; x.cpd = cpd; x.fu = fu; x.fl = fl; x.er = er; x.eiv = eiv; x.epd = epd;
    return x;
  endfunction

  function automatic vec_t idle(bit fu, bit fl, bit er, bit eiv, int epd);
    return v(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, fu, fl, er, eiv, epd);
  endfunction

  task automatic drive(input vec_t x);
    rst_n            = x.rst;
    dispatch_valid   = x.dv;
    dispatch_funct3  = 3'(x.pd);
    dispatch_ps1     = PRB'(x.ps1);
    dispatch_ps1_rdy = x.r1;
    dispatch_ps2     = PRB'(x.ps2);
    dispatch_ps2_rdy = x.r2;
    dispatch_pd      = PRB'(x.pd);
    dispatch_rob_idx = RIB'(x.rob);
    cdb_valid        = x.cv;
    cdb_pd           = PRB'(x.cpd);
    fu_valid         = x.fu;
    flush            = x.fl;
  endtask

  initial begin
    drive(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));

    vq.push_back(v(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));   // reset
    vq.push_back(idle(0, 0, 1, 0, 0));
    vq.push_back(v(1, 1, 5, 1, 6, 1, 9, 3, 0, 0, 0, 0, 1, 0, 0));   // ready mul
    vq.push_back(idle(0, 0, 1, 1, 9));                               // issued
    vq.push_back(idle(0, 0, 1, 0, 9));                               // one cycle only
    vq.push_back(idle(1, 0, 1, 0, 9));
    vq.push_back(v(1, 1, 7, 0, 6, 1, 10, 4, 0, 0, 0, 0, 1, 0, 9));  // ps1 pending
    vq.push_back(idle(0, 0, 1, 0, 9));
    vq.push_back(v(1, 0, 0, 0, 0, 0, 0, 0, 1, 7, 0, 0, 1, 0, 9));   // broadcast 7
    vq.push_back(idle(0, 0, 1, 1, 10));
    vq.push_back(idle(1, 0, 1, 0, 10));
    vq.push_back(v(1, 1, 7, 0, 0, 0, 11, 5, 1, 7, 0, 0, 1, 0, 10)); // wake on dispatch cycle, ps2=x0
    vq.push_back(idle(0, 0, 1, 1, 11));
    vq.push_back(idle(1, 0, 1, 0, 11));
    for (int k = 0; k < 4; k++)                                      // fill with waiting ops
      vq.push_back(v(1, 1, 20, 0, 21, 0, 12 + k, k, 0, 0, 0, 0, (k < 3), 0, 11));
    vq.push_back(v(1, 1, 20, 1, 21, 1, 16, 4, 0, 0, 0, 0, 0, 0, 11)); // dropped when full
    vq.push_back(idle(0, 0, 0, 0, 11));
    vq.push_back(v(1, 0, 0, 0, 0, 0, 0, 0, 1, 20, 0, 0, 0, 0, 11));
    vq.push_back(v(1, 0, 0, 0, 0, 0, 0, 0, 1, 21, 0, 0, 0, 0, 11));
    vq.push_back(idle(0, 0, 1, 1, 12));                              // slot 0 freed
    vq.push_back(v(1, 1, 1, 1, 2, 1, 17, 6, 0, 0, 0, 0, 0, 0, 12)); // reuses slot 0
    vq.push_back(idle(0, 0, 0, 0, 12));                              // held by busy unit
    vq.push_back(idle(1, 0, 0, 0, 12));                              // no issue on fu_valid cycle
    vq.push_back(idle(0, 0, 1, 1, 17));
    vq.push_back(idle(0, 0, 1, 0, 17));
    vq.push_back(idle(1, 0, 1, 0, 17));
    vq.push_back(idle(0, 0, 1, 1, 13));
    vq.push_back(v(1, 1, 30, 0, 31, 0, 18, 7, 0, 0, 0, 0, 1, 0, 13)); // three valid, busy
    vq.push_back(idle(0, 1, 1, 0, 13));                              // flush
    vq.push_back(idle(1, 0, 1, 0, 13));                              // late fu_valid ignored
    vq.push_back(v(1, 1, 0, 0, 0, 0, 19, 8, 0, 0, 0, 0, 1, 0, 13));
    vq.push_back(idle(0, 0, 1, 1, 19));
    vq.push_back(v(1, 1, 40, 0, 41, 0, 20, 9, 0, 0, 0, 0, 1, 0, 19));
    vq.push_back(v(1, 1, 40, 0, 41, 0, 21, 10, 0, 0, 0, 0, 1, 0, 19));
    vq.push_back(v(0, 1, 0, 1, 0, 1, 22, 11, 1, 40, 1, 1, 1, 0, 0)); // reset beats everything
    vq.push_back(v(1, 1, 0, 0, 0, 0, 23, 12, 0, 0, 0, 0, 1, 0, 0));
    vq.push_back(idle(0, 0, 1, 1, 23));
    vq.push_back(idle(0, 0, 1, 0, 23));

    for (int k = 0; k < vq.size(); k++) begin
      drive(vq[k]);
      tick();
      chk($sformatf("row%0d_dispatch_ready", k), {31'd0, dispatch_ready}, {31'd0, vq[k].er});
      chk($sformatf("row%0d_issue_valid", k), {31'd0, issue_valid}, {31'd0, vq[k].eiv});
      chk($sformatf("row%0d_issue_pd", k), {26'd0, issue_pd}, vq[k].epd);
    end

    for (int c = 0; c < 3000; c++) begin
      rst_n            = ($urandom_range(0, 199) != 0);
      flush            = ($urandom_range(0, 39) == 0);
      dispatch_valid   = ($urandom_range(0, 1) == 1);
      dispatch_funct3  = 3'($urandom_range(0, 7));
      dispatch_ps1     = PRB'($urandom_range(0, 7));
      dispatch_ps2     = PRB'($urandom_range(0, 7));
      dispatch_ps1_rdy = ($urandom_range(0, 3) == 0);
      dispatch_ps2_rdy = ($urandom_range(0, 3) == 0);
      dispatch_pd      = PRB'($urandom_range(0, 63));
      dispatch_rob_idx = RIB'($urandom_range(0, 15));
      cdb_valid        = ($urandom_range(0, 2) == 0);
      cdb_pd           = PRB'($urandom_range(0, 7));
      fu_valid         = ($urandom_range(0, 3) == 0);
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end
endmodule
